round_controller: RTL and testbench

ROUND_CONTROLLER -- requirements
Module: round_controller

---
 rtl/round_controller.sv | 186 ++++++++++++++++++
 tb/tb_round_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
`default_nettype none
// ============================================================================
//  Module   : round_controller
//  Purpose  : Sequencer for a memory/guessing game. Each round shows a random
//             target, waits for the player's entry, shows a verdict, and keeps
//             score and lives until the game is over.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1   system clock, rising edge
//    rst           in   1   asynchronous active-low reset
//    start         in   1   start/restart strobe (honoured in IDLE/OVER only)
//    randInt       in  16   free-running random source for the target
//    userInt       in  16   player's value, valid with valueReady
//    valueReady    in   1   single-cycle strobe for userInt
//    target        out 16   latched round target
//    displayPhase  out  1   target should be displayed
//    resultValid   out  1   verdict phase
//    resultOk      out  1   verdict of the last round
//    score         out  8   rounds won this game (saturates at 255)
//    lives         out  2   lives remaining
//    gameOver      out  1   game over
// ----------------------------------------------------------------------------
//  Build option
//    INPUT_TIMEOUT_EN : when defined, the input phase expires after
//                       INPUT_CYCLES cycles and counts as a lost round.
// ============================================================================
module round_controller #(
  parameter int unsigned SHOW_CYCLES   = 100000000,
  parameter int unsigned RESULT_CYCLES = 50000000,
  parameter int unsigned INPUT_CYCLES  = 500000000,
  parameter int unsigned LIVES         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] randInt,
  input  logic [15:0] userInt,
  input  logic        valueReady,
  output logic [15:0] target,
  output logic        displayPhase,
  output logic        resultValid,
  output logic        resultOk,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        gameOver
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_show   = 3'd1;
  localparam logic [2:0] c_st_input  = 3'd2;
  localparam logic [2:0] c_st_result = 3'd3;
  localparam logic [2:0] c_st_over   = 3'd4;

  localparam logic [31:0] c_show_load   = 32'(SHOW_CYCLES - 1);
  localparam logic [31:0] c_result_load = 32'(RESULT_CYCLES - 1);
  localparam logic [1:0]  c_lives_init  = 2'(LIVES);

`ifdef INPUT_TIMEOUT_EN
  localparam logic [31:0] c_input_load  = 32'(INPUT_CYCLES - 1);
`else
  // Parameter kept for interface compatibility; no timeout hardware exists.
  logic [31:0] input_cycles_unused;
  assign input_cycles_unused = 32'(INPUT_CYCLES);
`endif

  logic [2:0]  state_q,  state_d;
  logic [31:0] cnt_q,    cnt_d;
  logic [15:0] target_q, target_d;
  logic [7:0]  score_q,  score_d;
  logic [1:0]  lives_q,  lives_d;
  logic        ok_q,     ok_d;

  // A round is judged either by a user entry or (optionally) by expiry.
  logic        w_judge;
  logic        w_verdict;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    score_d   = score_q;
    lives_d   = lives_q;
    ok_d      = ok_q;
    w_judge   = 1'b0;
    w_verdict = 1'b0;

    case (state_q)
      c_st_idle, c_st_over: begin
        if (start) begin
          state_d  = c_st_show;
          target_d = randInt;
          score_d  = 8'd0;
          lives_d  = c_lives_init;
          cnt_d    = c_show_load;
        end
      end

      c_st_show: begin
        if (cnt_q == 32'd0) begin
          state_d = c_st_input;
`ifdef INPUT_TIMEOUT_EN
          cnt_d   = c_input_load;
`endif
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      c_st_input: begin
        // A genuine entry wins over expiry on the same cycle.
        if (valueReady) begin
          w_judge   = 1'b1;
          w_verdict = (userInt == target_q);
        end
`ifdef INPUT_TIMEOUT_EN
        else if (cnt_q == 32'd0) begin
          w_judge   = 1'b1;
          w_verdict = 1'b0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
`endif
        if (w_judge) begin
          state_d = c_st_result;
          cnt_d   = c_result_load;
          ok_d    = w_verdict;
          if (w_verdict) begin
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
          end else if (lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
          end
        end
      end

      c_st_result: begin
        if (cnt_q == 32'd0) begin
          if (lives_q == 2'd0) begin
            state_d = c_st_over;
          end else begin
            state_d  = c_st_show;
            target_d = randInt;
            cnt_d    = c_show_load;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= c_st_idle;
      cnt_q    <= 32'd0;
      target_q <= 16'd0;
      score_q  <= 8'd0;
      lives_q  <= 2'd0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      ok_q     <= ok_d;
    end
  end

  // Phase flags decode the registered state only.
  assign displayPhase = (state_q == c_st_show);
  assign resultValid  = (state_q == c_st_result);
  assign gameOver     = (state_q == c_st_over);
  assign target       = target_q;
  assign resultOk     = ok_q;
  assign score        = score_q;
  assign lives        = lives_q;

endmodule
`default_nettype wire

// File: tb/tb_round_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_round_controller
//  Purpose  : Self-checking bench for round_controller (vector table, directed
//             corner sequences, randomized run against a reference model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_round_controller;

  localparam int SHOW_C = 4;
  localparam int RES_C  = 2;
  localparam int IN_C   = 8;
  localparam int LV     = 3;
`ifdef INPUT_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        valueReady = 1'b0;
  logic [15:0] randInt = 16'd0;
  logic [15:0] userInt = 16'd0;
  logic [15:0] target;
  logic        displayPhase, resultValid, resultOk, gameOver;
  logic [7:0]  score;
  logic [1:0]  lives;

  always #5 clk = ~clk;

  round_controller #(
    .SHOW_CYCLES  (SHOW_C),
    .RESULT_CYCLES(RES_C),
    .INPUT_CYCLES (IN_C),
    .LIVES        (LV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .randInt     (randInt),
    .userInt     (userInt),
    .valueReady  (valueReady),
    .target      (target),
    .displayPhase(displayPhase),
    .resultValid (resultValid),
    .resultOk    (resultOk),
    .score       (score),
    .lives       (lives),
    .gameOver    (gameOver)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: phase + cycles spent in it ------------
  typedef enum int {P_IDLE, P_SHOW, P_INPUT, P_RESULT, P_OVER} phase_t;
  phase_t      m_phase;
  int          m_elapsed;
  logic [15:0] m_target;
  int          m_score;
  int          m_lives;
  bit          m_ok;

  function automatic void model_reset();
    m_phase = P_IDLE; m_elapsed = 0; m_target = 16'd0;
    m_score = 0; m_lives = 0; m_ok = 1'b0;
  endfunction

  function automatic void judge(input bit ok);
    m_phase = P_RESULT; m_elapsed = 0; m_ok = ok;
    if (ok) m_score = (m_score < 255) ? m_score + 1 : 255;
    else    m_lives = m_lives - 1;
  endfunction

  function automatic void model_step(input bit st, input logic [15:0] rnd,
                                     input logic [15:0] usr, input bit vr);
    case (m_phase)
      P_IDLE, P_OVER: if (st) begin
        m_phase = P_SHOW; m_elapsed = 0; m_target = rnd; m_score = 0; m_lives = LV;
      end
      P_SHOW: begin
        m_elapsed++;
        if (m_elapsed == SHOW_C) begin m_phase = P_INPUT; m_elapsed = 0; end
      end
      P_INPUT: begin
        m_elapsed++;
        if (vr) judge(usr == m_target);
        else if (TIMEOUT && m_elapsed == IN_C) judge(1'b0);
      end
      P_RESULT: begin
        m_elapsed++;
        if (m_elapsed == RES_C) begin
          if (m_lives == 0) m_phase = P_OVER;
          else begin m_phase = P_SHOW; m_elapsed = 0; m_target = rnd; end
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".displayPhase"}, 32'(displayPhase), 32'(m_phase == P_SHOW));
    chk({tag, ".resultValid"},  32'(resultValid),  32'(m_phase == P_RESULT));
    chk({tag, ".gameOver"},     32'(gameOver),     32'(m_phase == P_OVER));
    chk({tag, ".target"},       32'(target),       32'(m_target));
    chk({tag, ".score"},        32'(score),        32'(m_score));
    chk({tag, ".lives"},        32'(lives),        32'(m_lives));
    chk({tag, ".resultOk"},     32'(resultOk),     32'(m_ok));
  endtask

  // Called at posedge+1: drive, take the edge, advance model, settle.
  task automatic tick(input bit st, input logic [15:0] rnd, input logic [15:0] usr, input bit vr);
    start = st; randInt = rnd; userInt = usr; valueReady = vr;
    @(posedge clk);
    model_step(st, rnd, usr, vr);
    #1;
  endtask

  // Asserted between edges; outputs must clear without any clock edge.
  task automatic do_reset();
    rst = 1'b0; start = 1'b0; valueReady = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_until(input phase_t p, input string tag);
    int n = 0;
    while (m_phase != p && n < 60) begin
      tick(1'b0, 16'($urandom), 16'($urandom), 1'b0);
      check_model(tag);
      n++;
    end
    if (m_phase != p) begin
      n_checks++; n_fail++;
      $display("FAIL %s: phase %0d not reached within bound", tag, int'(p));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          st;
    logic [15:0] rnd;
    logic [15:0] usr;
    bit          vr;
    bit          disp;
    bit          rv;
    bit          ok;
    int          sc;
    int          lv;
    bit          go;
    logic [15:0] tgt;
  } vec_t;

  vec_t tbl[16];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 1'b0, 16'h1234};
    tbl[1]  = '{1'b0, 16'h5555, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 0, 3, 1'b0, 16'h1234};
    tbl[2]  = '{1'b1, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 1'b0, 16'h1234};
    tbl[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 1'b0, 16'h1234};
    tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0, 16'h1234};
    tbl[5]  = '{1'b1, 16'h9999, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0, 16'h1234};
    tbl[6]  = '{1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 1, 3, 1'b0, 16'h1234};
    tbl[7]  = '{1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1, 3, 1'b0, 16'h1234};
    tbl[8]  = '{1'b0, 16'hABCD, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1, 3, 1'b0, 16'hABCD};
    tbl[9]  = '{1'b0, 16'h0000, 16'hABCD, 1'b1, 1'b1, 1'b0, 1'b1, 1, 3, 1'b0, 16'hABCD};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1, 3, 1'b0, 16'hABCD};
    tbl[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1, 3, 1'b0, 16'hABCD};
    tbl[12] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 1'b0, 16'hABCD};
    tbl[13] = '{1'b0, 16'h0000, 16'hABCC, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 1'b0, 16'hABCD};
    tbl[14] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2, 1'b0, 16'hABCD};
    tbl[15] = '{1'b0, 16'h0777, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 1'b0, 16'h0777};

    // Reset state, then idle with noise: nothing may move without start.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      check_model("idle_hold");
    end

    // Table: show timing, first verdict, ignored strobes, target latching.
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].st, tbl[i].rnd, tbl[i].usr, tbl[i].vr);
      chk($sformatf("tbl%0d.displayPhase", i), 32'(displayPhase), 32'(tbl[i].disp));
      chk($sformatf("tbl%0d.resultValid", i),  32'(resultValid),  32'(tbl[i].rv));
      chk($sformatf("tbl%0d.resultOk", i),     32'(resultOk),     32'(tbl[i].ok));
      chk($sformatf("tbl%0d.score", i),        32'(score),        32'(tbl[i].sc));
      chk($sformatf("tbl%0d.lives", i),        32'(lives),        32'(tbl[i].lv));
      chk($sformatf("tbl%0d.gameOver", i),     32'(gameOver),     32'(tbl[i].go));
      chk($sformatf("tbl%0d.target", i),       32'(target),       32'(tbl[i].tgt));
    end

    // One win, three losses, game over, score held, restart.
    do_reset();
    tick(1'b1, 16'h4242, 16'h0, 1'b0); check_model("go_start");
    run_until(P_INPUT, "go_win_wait");
    tick(1'b0, 16'h0, m_target, 1'b1); check_model("go_win");
    for (int k = 0; k < 3; k++) begin
      run_until(P_INPUT, "go_loss_wait");
      tick(1'b0, 16'h0, ~m_target, 1'b1); check_model("go_loss");
      chk("go_lives_after_loss", 32'(lives), 32'(2 - k));
    end
    run_until(P_OVER, "go_over_wait");
    chk("go_gameOver", 32'(gameOver), 32'd1);
    chk("go_score_held", 32'(score), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 16'($urandom), 16'($urandom), 1'b1); check_model("go_over_hold");
    end
    tick(1'b1, 16'h0BEE, 16'h0, 1'b0); check_model("go_restart");
    chk("go_restart_score", 32'(score), 32'd0);
    chk("go_restart_lives", 32'(lives), 32'd3);
    chk("go_restart_show",  32'(displayPhase), 32'd1);

    // Input phase: indefinite wait, or timeout with entry priority.
    run_until(P_INPUT, "in_wait");
    if (TIMEOUT) begin
      for (int k = 0; k < IN_C - 1; k++) begin
        tick(1'b0, 16'h0, 16'h0, 1'b0); check_model("to_wait");
      end
      chk("to_not_yet", 32'(resultValid), 32'd0);
      tick(1'b0, 16'h0, 16'h0, 1'b0); check_model("to_expire");
      chk("to_expire_rv",    32'(resultValid), 32'd1);
      chk("to_expire_ok",    32'(resultOk),    32'd0);
      chk("to_expire_lives", 32'(lives),       32'd2);
      run_until(P_INPUT, "to_wait2");
      for (int k = 0; k < IN_C - 1; k++) begin
        tick(1'b0, 16'h0, 16'h0, 1'b0); check_model("to_wait2");
      end
      tick(1'b0, 16'h0, m_target, 1'b1); check_model("to_last_cycle");
      chk("to_last_cycle_ok", 32'(resultOk), 32'd1);
    end else begin
      for (int k = 0; k < 40; k++) begin
        tick(1'b0, 16'h0, 16'h0, 1'b0); check_model("no_timeout");
      end
      chk("no_timeout_rv", 32'(resultValid), 32'd0);
    end

    // Reset mid-SHOW and mid-RESULT.
    tick(1'b1, 16'h0, 16'h0, 1'b0);
    do_reset();
    tick(1'b1, 16'h7777, 16'h0, 1'b0); tick(1'b0, 16'h0, 16'h0, 1'b0);
    check_model("pre_reset_show");
    do_reset();
    chk("reset_show_target", 32'(target), 32'd0);
    tick(1'b1, 16'h3333, 16'h0, 1'b0);
    run_until(P_INPUT, "rr_wait");
    tick(1'b0, 16'h0, m_target, 1'b1); check_model("pre_reset_result");
    do_reset();
    chk("reset_result_score", 32'(score), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 16'($urandom), 16'($urandom), 1'($urandom)); check_model("post_reset_idle");
    end

    // Score saturation at 255.
    tick(1'b1, 16'h1111, 16'h0, 1'b0);
    for (int k = 0; k < 258; k++) begin
      run_until(P_INPUT, "sat_wait");
      tick(1'b0, 16'h0, m_target, 1'b1); check_model("sat_win");
    end
    chk("score_saturated", 32'(score), 32'd255);

    // Randomized run against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        tick(($urandom_range(0, 15) == 0), 16'($urandom),
             ($urandom_range(0, 1) == 0) ? m_target : 16'($urandom),
             ($urandom_range(0, 3) == 0));
        check_model("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
